// File: rtl/snes_pkg.sv
// Shared SNES pad-link definitions, used by both the pad emulator and the host-side reader.
// Pure constants and types: no clocked logic, no flow control.
package snes_pkg;

    localparam int NUM_BUTTONS = 12;
    localparam int FRAME_BITS  = 16;
    localparam int COUNT_W     = $clog2(FRAME_BITS + 1);
    localparam logic [3:0] PAD_ID = 4'b1111;

    // Bit positions inside button_data and inside the serial frame, LSB first
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LATCHED  = 2'd1,
        ST_SHIFTING = 2'd2,
        ST_DONE     = 2'd3
    } snes_state_t;

    // The wire is active-low, and the ID nibble sits above the button bits.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [NUM_BUTTONS-1:0] btn);
        return {PAD_ID, ~btn};
    endfunction

endpackage

// File: rtl/snes_pad_if.sv
// Connector-side pad pins plus frame status; master = host/game side, slave = pad emulator.
// Plain wires: no handshake, the host clocks data at its own pace.
interface snes_pad_if;
    import snes_pkg::*;

    logic                   data_latch;
    logic                   snes_clk;
    logic [NUM_BUTTONS-1:0] button_data;
    logic                   serial_data;
    logic [COUNT_W-1:0]     bit_count;
    logic                   frame_done;
    logic                   frame_abort;

    modport master (
        output data_latch, snes_clk, button_data,
        input  serial_data, bit_count, frame_done, frame_abort
    );

    modport slave (
        input  data_latch, snes_clk, button_data,
        output serial_data, bit_count, frame_done, frame_abort
    );

endinterface

// File: rtl/snes_input_filter.sv
// 2-FF synchronizer plus stability filter for one asynchronous pin.
// Latency: 2 sync cycles + FILTER_LEN stable cycles; no backpressure.
module snes_input_filter #(
    parameter int   FILTER_LEN = 4,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic          meta;
    logic          sync;
    logic [CW-1:0] stable_cnt;

    // The filtered level flips only once sync has disagreed with it for FILTER_LEN straight cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta       <= RESET_VAL;
            sync       <= RESET_VAL;
            dout       <= RESET_VAL;
            stable_cnt <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            if (sync != dout) begin
                if (stable_cnt == CW'(FILTER_LEN - 1)) begin
                    dout       <= sync;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/snes_pad_emulator.sv
// Device end of the SNES pad link: latches 12 buttons and shifts them out LSB-first, active-low.
// Pin edge to serial_data: FILTER_LEN+3 clk cycles; host paces the shifts, no backpressure.
module snes_pad_emulator
    import snes_pkg::*;
#(
    parameter int   FILTER_LEN = 4,
    parameter int   TIMEOUT    = 2000,
    parameter logic FILL_BIT   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    snes_pad_if.slave  pad
);

    logic latch_f;
    logic sclk_f;
    logic sclk_f_d;
    logic sclk_rise;

    snes_input_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b0)) u_latch_filter (
        .clk   (clk),
        .reset (reset),
        .din   (pad.data_latch),
        .dout  (latch_f)
    );

    snes_input_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_sclk_filter (
        .clk   (clk),
        .reset (reset),
        .din   (pad.snes_clk),
        .dout  (sclk_f)
    );

    assign sclk_rise = sclk_f & ~sclk_f_d;

    snes_state_t           state,      state_n;
    logic [FRAME_BITS-1:0] shreg,      shreg_n;
    logic [COUNT_W-1:0]    bit_cnt,    bit_cnt_n;
    logic [15:0]           to_cnt,     to_cnt_n;
    logic                  done_q,     done_n;
    logic                  abort_q,    abort_n;

    logic [FRAME_BITS-1:0] load_word;
    logic [FRAME_BITS-1:0] shifted;
    logic [15:0]           to_inc;
    logic                  timeout_hit;

    assign load_word   = frame_word(pad.button_data);
    assign shifted     = {FILL_BIT, shreg[FRAME_BITS-1:1]};
    assign to_inc      = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
    assign timeout_hit = (32'(to_inc) >= TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '1;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            sclk_f_d <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            to_cnt   <= to_cnt_n;
            done_q   <= done_n;
            abort_q  <= abort_n;
            sclk_f_d <= sclk_f;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        to_cnt_n  = to_cnt;
        done_n    = 1'b0;
        abort_n   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                shreg_n   = '1;
                bit_cnt_n = '0;
                to_cnt_n  = '0;
                if (latch_f) begin
                    state_n = ST_LATCHED;
                    shreg_n = load_word;
                end
            end

            // Track the buttons while the latch is held; the last load is what gets shifted.
            ST_LATCHED: begin
                bit_cnt_n = '0;
                to_cnt_n  = '0;
                if (latch_f) begin
                    shreg_n = load_word;
                end else begin
                    state_n = ST_SHIFTING;
                end
            end

            // Latch is checked first so a coincident clock edge is dropped.
            ST_SHIFTING: begin
                if (latch_f) begin
                    state_n   = ST_LATCHED;
                    shreg_n   = load_word;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                    abort_n   = 1'b1;
                end else if (sclk_rise) begin
                    shreg_n   = shifted;
                    bit_cnt_n = bit_cnt + 1'b1;
                    to_cnt_n  = '0;
                    if (bit_cnt == COUNT_W'(FRAME_BITS - 1)) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_n   = ST_IDLE;
                    shreg_n   = '1;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                    abort_n   = 1'b1;
                end else begin
                    to_cnt_n = to_inc;
                end
            end

            ST_DONE: begin
                if (latch_f) begin
                    state_n   = ST_LATCHED;
                    shreg_n   = load_word;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                end else if (sclk_rise) begin
                    shreg_n  = shifted;
                    to_cnt_n = '0;
                end else if (timeout_hit) begin
                    state_n   = ST_IDLE;
                    shreg_n   = '1;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                end else begin
                    to_cnt_n = to_inc;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign pad.serial_data = shreg[0];
    assign pad.bit_count   = bit_cnt;
    assign pad.frame_done  = done_q;
    assign pad.frame_abort = abort_q;

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Directed host-side stimulus for the SNES pad emulator with immediate-assertion checks.
module tb_snes_pad_emulator;

    localparam int H       = 150;   // host half period (6 us at 25 MHz)
    localparam int LATCH_T = 300;   // 12 us latch pulse

    logic clk   = 1'b0;
    logic reset = 1'b1;

    snes_pad_if pad ();

    snes_pad_emulator #(
        .FILTER_LEN (4),
        .TIMEOUT    (2000),
        .FILL_BIT   (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pad   (pad)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passes = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;

    always @(negedge clk) begin
        if (pad.frame_done)  done_cnt  <= done_cnt + 1;
        if (pad.frame_abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch_pulse();
        pad.data_latch = 1'b1;
        cyc(LATCH_T);
        pad.data_latch = 1'b0;
        cyc(H);
    endtask

    task automatic pulse_edges(input int n);
        for (int i = 0; i < n; i++) begin
            pad.snes_clk = 1'b0;
            cyc(H);
            pad.snes_clk = 1'b1;
            cyc(H);
        end
    endtask

    // Samples each bit when the host clock falls, then raises it to shift the next bit.
    task automatic read_frame(output logic [15:0] word, input int glitch_at);
        word = '0;
        for (int i = 0; i < 16; i++) begin
            pad.snes_clk = 1'b0;
            word[i] = pad.serial_data;
            if (i == glitch_at) begin
                cyc(50);
                check("glitch_pre_count", 32'(pad.bit_count), 32'(i));
                pad.snes_clk = 1'b1;
                cyc(2);
                pad.snes_clk = 1'b0;
                cyc(20);
                check("glitch_no_shift", 32'(pad.bit_count), 32'(i));
                cyc(H - 72);
            end else begin
                cyc(H);
            end
            pad.snes_clk = 1'b1;
            cyc(H);
        end
    endtask

    logic [15:0] word;
    int d0, a0;

    initial begin
        pad.data_latch  = 1'b0;
        pad.snes_clk    = 1'b1;
        pad.button_data = 12'h000;
        cyc(3);
        check("reset_serial",  32'(pad.serial_data), 32'h1);
        check("reset_count",   32'(pad.bit_count),   32'h0);
        check("reset_done",    32'(pad.frame_done),  32'h0);
        check("reset_abort",   32'(pad.frame_abort), 32'h0);
        reset = 1'b0;
        cyc(5);

        // Frame 1: B pressed, with exact latch-to-serial latency
        pad.button_data = 12'h001;
        d0 = done_cnt; a0 = abort_cnt;
        pad.data_latch = 1'b1;
        cyc(6);
        check("latency_before", 32'(pad.serial_data), 32'h1);
        cyc(1);
        check("latency_at",     32'(pad.serial_data), 32'h0);
        cyc(LATCH_T - 7);
        pad.data_latch = 1'b0;
        cyc(H);
        read_frame(word, -1);
        check("f1_word",  32'(word),            32'h0000FFFE);
        check("f1_count", 32'(pad.bit_count),   32'd16);
        check("f1_done",  32'(done_cnt - d0),   32'd1);
        check("f1_abort", 32'(abort_cnt - a0),  32'd0);

        // Frame 2: buttons 4,6,9,11 with a glitch mid-frame, then a 17th edge
        pad.button_data = 12'hA50;
        d0 = done_cnt; a0 = abort_cnt;
        latch_pulse();
        read_frame(word, 6);
        check("f2_word", 32'(word), 32'h0000F5AF);
        pad.snes_clk = 1'b0;
        check("f2_fill", 32'(pad.serial_data), 32'h0);
        cyc(H);
        pad.snes_clk = 1'b1;
        cyc(H);
        check("f2_count_sat", 32'(pad.bit_count),  32'd16);
        check("f2_done_once", 32'(done_cnt - d0),  32'd1);
        check("f2_abort",     32'(abort_cnt - a0), 32'd0);

        // Timeout: host stops after 5 edges
        pad.button_data = 12'h020;
        d0 = done_cnt; a0 = abort_cnt;
        latch_pulse();
        pulse_edges(4);
        pad.snes_clk = 1'b0;
        cyc(H);
        pad.snes_clk = 1'b1;
        cyc(7);
        check("to_count5",  32'(pad.bit_count),   32'd5);
        check("to_serial0", 32'(pad.serial_data), 32'h0);
        cyc(1999);
        check("to_abort_early", 32'(pad.frame_abort), 32'h0);
        cyc(1);
        check("to_abort_pulse", 32'(pad.frame_abort), 32'h1);
        check("to_idle_serial", 32'(pad.serial_data), 32'h1);
        check("to_idle_count",  32'(pad.bit_count),   32'h0);
        cyc(1);
        check("to_abort_single", 32'(abort_cnt - a0), 32'd1);
        check("to_no_done",      32'(done_cnt - d0),   32'd0);

        // Re-latch after 8 edges with new buttons
        pad.button_data = 12'h155;
        latch_pulse();
        pulse_edges(8);
        d0 = done_cnt; a0 = abort_cnt;
        pad.button_data = 12'h800;
        latch_pulse();
        check("rl_abort", 32'(abort_cnt - a0), 32'd1);
        read_frame(word, -1);
        check("rl_word",  32'(word),            32'h0000F7FF);
        check("rl_done",  32'(done_cnt - d0),   32'd1);

        // Reset in the middle of shifting
        pad.button_data = 12'h008;
        latch_pulse();
        pulse_edges(3);
        check("rst_pre_serial", 32'(pad.serial_data), 32'h0);
        check("rst_pre_count",  32'(pad.bit_count),   32'd3);
        d0 = done_cnt; a0 = abort_cnt;
        reset = 1'b1;
        cyc(1);
        check("rst_serial", 32'(pad.serial_data), 32'h1);
        check("rst_count",  32'(pad.bit_count),   32'h0);
        check("rst_done",   32'(pad.frame_done),  32'h0);
        check("rst_abort",  32'(pad.frame_abort), 32'h0);
        reset = 1'b0;
        cyc(20);
        check("rst_no_pulses", 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);
        check("rst_idle_serial", 32'(pad.serial_data), 32'h1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
